// File: rtl/bank_xbar_rob_pkg.sv
// Shared constants and types for the bank xbar reorder buffer.
package bank_pkg;
    localparam int CH_NUM      = 3;
    localparam int ROB_DEPTH   = 8;
    localparam int ROB_NUM_W   = $clog2(ROB_DEPTH);
    localparam int XBAR_DATA_W = 128;
    localparam int CH_ID_W     = 2;

    typedef logic [CH_ID_W-1:0]     ch_id_t;
    typedef logic [ROB_NUM_W-1:0]   rob_num_t;
    typedef logic [XBAR_DATA_W-1:0] xbar_data_t;

    // Channel ids at or above CH_NUM are encodable but have no ROB behind them.
    function automatic logic ch_legal(ch_id_t ch);
        return (int'(ch) < CH_NUM);
    endfunction
endpackage

// File: rtl/bank_xbar_rob_if.sv
// SRAM-controller response port plus per-channel in-order return path.
interface bank_xbar_rob_if;
    import bank_pkg::*;

    logic                            sc_xbar_valid_i;
    logic                            sc_xbar_ready_o;
    ch_id_t                          sc_xbar_channel_id_i;
    rob_num_t                        sc_xbar_rob_num_i;
    xbar_data_t                      sc_xbar_data_i;
    logic [CH_NUM-1:0]               rob_xbar_rvalid_o;
    logic [CH_NUM-1:0]               rob_xbar_rready_i;
    logic [CH_NUM*XBAR_DATA_W-1:0]   rob_xbar_rdata_o;
    logic [CH_NUM-1:0]               xbar_isu_credit_o;
    logic                            rob_err_o;

    // Producer side: SRAM controller responses in, consumers pull and see credits.
    modport master (
        output sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
        output rob_xbar_rready_i,
        input  sc_xbar_ready_o, rob_xbar_rvalid_o, rob_xbar_rdata_o,
        input  xbar_isu_credit_o, rob_err_o
    );

    // The reorder buffer itself.
    modport slave (
        input  sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
        input  rob_xbar_rready_i,
        output sc_xbar_ready_o, rob_xbar_rvalid_o, rob_xbar_rdata_o,
        output xbar_isu_credit_o, rob_err_o
    );
endinterface

// File: rtl/bank_xbar_rob_ch.sv
// One channel's reorder slots, release head pointer and credit-return flop.
module bank_xbar_rob_ch
    import bank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  rob_num_t   i_rob_num,
    input  logic       i_wr_en,
    input  xbar_data_t i_wr_data,
    output logic       o_slot_busy,
    input  logic       i_rready,
    output logic       o_rvalid,
    output xbar_data_t o_rdata,
    output logic       o_credit
);
    logic [ROB_DEPTH-1:0] r_valid;
    xbar_data_t           r_data [ROB_DEPTH];
    rob_num_t             r_head;
    logic                 r_credit;
    logic                 w_pop;

    assign o_slot_busy = r_valid[i_rob_num];
    assign o_rvalid    = r_valid[r_head];
    assign o_rdata     = r_data[r_head];
    assign o_credit    = r_credit;
    assign w_pop       = o_rvalid & i_rready;

    // Slot occupancy, head advance and credit pulse. A write never targets
    // the popping slot because that slot is still valid and blocks the write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= '0;
            r_head   <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (i_wr_en)
                r_valid[i_rob_num] <= 1'b1;
        end
    end

    // Payload storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (i_wr_en)
            r_data[i_rob_num] <= i_wr_data;
    end
endmodule

// File: rtl/bank_xbar_rob.sv
// Reorder buffer: out-of-order tagged responses in, per-channel in-order out.
module bank_xbar_rob
    import bank_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    bank_xbar_rob_if.slave        xbar
);
    logic                                w_legal;
    logic                                w_tgt_busy;
    logic                                w_accept;
    logic [CH_NUM-1:0]                   w_busy;
    logic [CH_NUM-1:0]                   w_wr_en;
    logic [CH_NUM-1:0]                   w_rvalid;
    logic [CH_NUM-1:0]                   w_credit;
    logic [CH_NUM-1:0][XBAR_DATA_W-1:0]  w_rdata;
    logic                                r_err;

    assign w_legal = ch_legal(xbar.sc_xbar_channel_id_i);

    // Occupancy of the addressed slot; illegal ids never look busy so they drain.
    always_comb begin
        w_tgt_busy = 1'b0;
        for (int c = 0; c < CH_NUM; c++)
            if (w_legal && xbar.sc_xbar_channel_id_i == ch_id_t'(c))
                w_tgt_busy = w_busy[c];
    end

    assign xbar.sc_xbar_ready_o = ~w_tgt_busy;
    assign w_accept             = xbar.sc_xbar_valid_i & ~w_tgt_busy;

    generate
        for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
            assign w_wr_en[c] = w_accept & w_legal &
                                (xbar.sc_xbar_channel_id_i == ch_id_t'(c));

            bank_xbar_rob_ch u_ch (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .i_rob_num   (xbar.sc_xbar_rob_num_i),
                .i_wr_en     (w_wr_en[c]),
                .i_wr_data   (xbar.sc_xbar_data_i),
                .o_slot_busy (w_busy[c]),
                .i_rready    (xbar.rob_xbar_rready_i[c]),
                .o_rvalid    (w_rvalid[c]),
                .o_rdata     (w_rdata[c]),
                .o_credit    (w_credit[c])
            );
        end
    endgenerate

    // Sticky error: illegal channel id, or a response aimed at an occupied slot.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_err <= 1'b0;
        else if (xbar.sc_xbar_valid_i && (!w_legal || w_tgt_busy))
            r_err <= 1'b1;
    end

    assign xbar.rob_xbar_rvalid_o = w_rvalid;
    assign xbar.rob_xbar_rdata_o  = w_rdata;
    assign xbar.xbar_isu_credit_o = w_credit;
    assign xbar.rob_err_o         = r_err;
endmodule

// File: tb/tb_bank_xbar_rob.sv
// Self-checking bench for bank_xbar_rob: vector table, directed sequences, random vs model.
module tb_bank_xbar_rob;
    import bank_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_xbar_rob_if u_if ();

    bank_xbar_rob u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .xbar  (u_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: per channel, a map rob->entry and a running count of
    // releases; the slot next due is that count modulo ROB_DEPTH.
    bit           m_val  [CH_NUM][ROB_DEPTH];
    logic [127:0] m_data [CH_NUM][ROB_DEPTH];
    int           m_rel  [CH_NUM];
    bit           m_cred [CH_NUM];
    bit           m_err;

    // Currently driven stimulus
    bit           g_v;
    logic [1:0]   g_ch;
    logic [2:0]   g_rob;
    logic [127:0] g_d;
    logic [2:0]   g_rr;
    bit           g_rst;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH_NUM; c++) begin
            m_rel[c]  = 0;
            m_cred[c] = 0;
            for (int s = 0; s < ROB_DEPTH; s++) m_val[c][s] = 0;
        end
        m_err = 0;
    endtask

    function automatic bit exp_ready();
        if (int'(g_ch) >= CH_NUM) return 1'b1;
        return !m_val[g_ch][g_rob];
    endfunction

    // Drive inputs just after a rising edge and let combinational outputs settle.
    task automatic apply(input bit v, input logic [1:0] ch, input logic [2:0] rob,
                         input logic [127:0] d, input logic [2:0] rr, input bit r);
        g_v = v; g_ch = ch; g_rob = rob; g_d = d; g_rr = rr; g_rst = r;
        u_if.sc_xbar_valid_i      = v;
        u_if.sc_xbar_channel_id_i = ch;
        u_if.sc_xbar_rob_num_i    = rob;
        u_if.sc_xbar_data_i       = d;
        u_if.rob_xbar_rready_i    = rr;
        rst                       = r;
        #1;
    endtask

    task automatic model_chk();
        chk("ready", u_if.sc_xbar_ready_o, exp_ready());
        for (int c = 0; c < CH_NUM; c++) begin
            int  s;
            bit  erv;
            s   = m_rel[c] % ROB_DEPTH;
            erv = m_val[c][s];
            chk($sformatf("rvalid%0d", c), u_if.rob_xbar_rvalid_o[c], erv);
            if (erv)
                chk($sformatf("rdata%0d", c), u_if.rob_xbar_rdata_o[c*XBAR_DATA_W +: XBAR_DATA_W], m_data[c][s]);
            chk($sformatf("credit%0d", c), u_if.xbar_isu_credit_o[c], m_cred[c]);
        end
        chk("err", u_if.rob_err_o, m_err);
    endtask

    // Update the model with what the clock edge will do, then take the edge.
    task automatic advance();
        bit rdy;
        rdy = exp_ready();
        if (g_rst) model_reset();
        else begin
            for (int c = 0; c < CH_NUM; c++) begin
                int s;
                s = m_rel[c] % ROB_DEPTH;
                m_cred[c] = m_val[c][s] && g_rr[c];
                if (m_cred[c]) begin
                    m_val[c][s] = 0;
                    m_rel[c]++;
                end
            end
            if (g_v) begin
                if (int'(g_ch) >= CH_NUM || !rdy) m_err = 1;
                else begin
                    m_val[g_ch][g_rob]  = 1;
                    m_data[g_ch][g_rob] = g_d;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [1:0] ch, input logic [2:0] rob,
                        input logic [127:0] d, input logic [2:0] rr);
        apply(v, ch, rob, d, rr, 1'b0);
        model_chk();
        advance();
    endtask

    task automatic do_reset();
        apply(1'b0, 2'd0, 3'd0, '0, 3'b000, 1'b1);
        advance();
    endtask

    typedef struct {
        bit         v;
        logic [1:0] ch;
        logic [2:0] rob;
        logic [7:0] db;
        logic [2:0] rr;
        bit         e_ready;
        logic [2:0] e_rvalid;
        logic [7:0] e_db0;
        logic [2:0] e_cred;
        bit         e_err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int ncred;
        logic [127:0] held;

        // ch0 writes rob 0,1,2 in order with everything ready.
        tbl[0] = '{0, 2'd0, 3'd0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 3'b000, 0};
        tbl[1] = '{1, 2'd0, 3'd0, 8'hA0, 3'b111, 1, 3'b000, 8'h00, 3'b000, 0};
        tbl[2] = '{1, 2'd0, 3'd1, 8'hA1, 3'b111, 1, 3'b001, 8'hA0, 3'b000, 0};
        tbl[3] = '{1, 2'd0, 3'd2, 8'hA2, 3'b111, 1, 3'b001, 8'hA1, 3'b001, 0};
        tbl[4] = '{0, 2'd0, 3'd0, 8'h00, 3'b111, 1, 3'b001, 8'hA2, 3'b001, 0};
        tbl[5] = '{0, 2'd0, 3'd0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 3'b001, 0};
        tbl[6] = '{0, 2'd0, 3'd0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 3'b000, 0};

        model_reset();
        do_reset();
        do_reset();

        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].v, tbl[i].ch, tbl[i].rob, {16{tbl[i].db}}, tbl[i].rr, 1'b0);
            chk($sformatf("t%0d_ready", i),  u_if.sc_xbar_ready_o,   tbl[i].e_ready);
            chk($sformatf("t%0d_rvalid", i), u_if.rob_xbar_rvalid_o, tbl[i].e_rvalid);
            if (tbl[i].e_rvalid[0])
                chk($sformatf("t%0d_rdata0", i), u_if.rob_xbar_rdata_o[XBAR_DATA_W-1:0], {16{tbl[i].e_db0}});
            chk($sformatf("t%0d_credit", i), u_if.xbar_isu_credit_o, tbl[i].e_cred);
            chk($sformatf("t%0d_err", i),    u_if.rob_err_o,         tbl[i].e_err);
            advance();
        end

        // ch1 out of order: rob 2, then 0, then 1.
        step(1, 2'd1, 3'd2, {4{32'h1100_0002}}, 3'b111);
        step(0, 2'd0, 3'd0, '0, 3'b111);
        chk("ch1_hold_rvalid", u_if.rob_xbar_rvalid_o[1], 1'b0);
        step(0, 2'd0, 3'd0, '0, 3'b111);
        step(1, 2'd1, 3'd0, {4{32'h1100_0000}}, 3'b111);
        step(1, 2'd1, 3'd1, {4{32'h1100_0001}}, 3'b111);
        for (int i = 0; i < 4; i++) step(0, 2'd0, 3'd0, '0, 3'b111);

        // ch2: 12 in-order responses, head wraps.
        ncred = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 12) apply(1, 2'd2, 3'(i % 8), {4{32'h2200_0000 + i}}, 3'b111, 1'b0);
            else        apply(0, 2'd0, 3'd0, '0, 3'b111, 1'b0);
            ncred += int'(u_if.xbar_isu_credit_o[2]);
            model_chk();
            advance();
        end
        chk("ch2_credits", ncred, 12);
        chk("ch2_noerr", u_if.rob_err_o, 1'b0);

        // ch0 stall with rready low, then collision on the occupied head slot.
        do_reset();
        step(1, 2'd0, 3'd0, {4{32'hC0DE_0000}}, 3'b000);
        held = u_if.rob_xbar_rdata_o[XBAR_DATA_W-1:0];
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd0, 3'd0, '0, 3'b000);
            chk("stall_rvalid", u_if.rob_xbar_rvalid_o[0], 1'b1);
            chk("stall_rdata", u_if.rob_xbar_rdata_o[XBAR_DATA_W-1:0], held);
        end
        apply(1, 2'd0, 3'd0, {4{32'hBEEF_0000}}, 3'b000, 1'b0);
        chk("coll_ready", u_if.sc_xbar_ready_o, 1'b0);
        model_chk();
        advance();
        chk("coll_err", u_if.rob_err_o, 1'b1);
        apply(1, 2'd0, 3'd0, {4{32'hBEEF_0000}}, 3'b001, 1'b0);
        chk("pop_cycle_ready", u_if.sc_xbar_ready_o, 1'b0);
        model_chk();
        advance();
        apply(1, 2'd0, 3'd0, {4{32'hBEEF_0000}}, 3'b001, 1'b0);
        chk("after_pop_ready", u_if.sc_xbar_ready_o, 1'b1);
        model_chk();
        advance();
        for (int i = 0; i < 3; i++) step(0, 2'd0, 3'd0, '0, 3'b111);

        // Illegal channel id: accepted, dropped, sticky error.
        do_reset();
        apply(1, 2'd3, 3'd0, {4{32'hDEAD_0003}}, 3'b111, 1'b0);
        chk("ill_ready", u_if.sc_xbar_ready_o, 1'b1);
        model_chk();
        advance();
        for (int i = 0; i < 4; i++) begin
            step(0, 2'd0, 3'd0, '0, 3'b111);
            chk("ill_rvalid", u_if.rob_xbar_rvalid_o, 3'b000);
            chk("ill_err", u_if.rob_err_o, 1'b1);
        end

        // All channels pop together, then reset mid-stream.
        do_reset();
        chk("rst_err", u_if.rob_err_o, 1'b0);
        for (int c = 0; c < CH_NUM; c++) step(1, 2'(c), 3'd0, {4{32'hA11_0000 + c}}, 3'b000);
        step(0, 2'd0, 3'd0, '0, 3'b111);
        chk("all_credit", u_if.xbar_isu_credit_o, 3'b111);
        for (int c = 0; c < CH_NUM; c++) step(1, 2'(c), 3'd1, {4{32'hB22_0000 + c}}, 3'b000);
        step(1, 2'd0, 3'd3, {4{32'hB22_0003}}, 3'b000);
        apply(1, 2'd1, 3'd2, '0, 3'b111, 1'b1);
        advance();
        apply(0, 2'd0, 3'd0, '0, 3'b111, 1'b0);
        chk("midrst_rvalid", u_if.rob_xbar_rvalid_o, 3'b000);
        chk("midrst_credit", u_if.xbar_isu_credit_o, 3'b000);
        chk("midrst_err", u_if.rob_err_o, 1'b0);
        advance();

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] ch;
            if (i % 400 == 399) begin
                do_reset();
                continue;
            end
            ch = ($urandom_range(0, 63) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(bit'($urandom_range(0, 1)), ch, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bank_xbar_rob.md
Name: bank_xbar_rob

Overview:
- Per-channel reorder buffer between the bank SRAM controller's xbar response port (sc_xbar_*) and the xbar return path.
- Accepts read responses tagged with channel id and ROB number, possibly out of order.
- Releases them to each channel strictly in ROB-number order.
- Returns one credit per released entry to the ISU. Replaces the fake xbar counter model in the bank top.

Parameters:
CH_NUM, 3, number of xbar channels (channel ids 0..CH_NUM-1)
ROB_DEPTH, 8, entries per channel; ROB number width = log2(ROB_DEPTH) = 3
DATA_WIDTH, 128, response data width

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock; reset is synchronous and active-high
sc_xbar_valid_i  input  1  response valid from SRAM controller
sc_xbar_ready_o  output  1  response accepted
sc_xbar_channel_id_i  input  2  destination channel
sc_xbar_rob_num_i  input  3  ROB slot assigned by ISU
sc_xbar_data_i  input  DATA_WIDTH  response data
rob_xbar_rvalid_o  output  CH_NUM  per-channel in-order response valid
rob_xbar_rready_i  input  CH_NUM  per-channel consumer ready
rob_xbar_rdata_o  output  CH_NUM*DATA_WIDTH  per-channel data; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
xbar_isu_credit_o  output  CH_NUM  one-cycle credit-return pulse per channel
rob_err_o  output  1  sticky protocol-error flag

Behaviour:
- State per channel: valid[ROB_DEPTH], data[ROB_DEPTH], head pointer (3 bits).
- Reset (synchronous): all valid=0, heads=0, credit=0, rob_err_o=0. rvalid_o=0 follows from the valid bits; rdata_o is don't-care but must not be X-propagating into valid. Reset mid-operation discards all stored entries and owes no credits.
- Write acceptance:
  - sc_xbar_ready_o = 1 when channel_id < CH_NUM and valid[ch][rob_num]==0.
  - sc_xbar_ready_o = 1 when channel_id >= CH_NUM (illegal id: accept and drop, set rob_err_o).
  - sc_xbar_ready_o = 0 when the target slot is occupied (collision). Hold ready low while valid is asserted; set rob_err_o on the first such cycle. ready may depend combinationally on valid/id/rob_num.
  - On valid&&ready with a legal id: data[ch][rob_num] <= data_i, valid[ch][rob_num] <= 1 at the next edge.
- Release:
  - rob_xbar_rvalid_o[c] = valid[c][head[c]]; rdata_o[c] = data[c][head[c]]. Both are combinational from registered state.
  - Latency: a write to the head slot appears on rvalid the cycle after acceptance (1 cycle).
  - On rvalid[c]&&rready[c]: valid[c][head] <= 0, head[c] <= head[c]+1 (wraps 7->0 naturally), xbar_isu_credit_o[c] <= 1 for exactly the next cycle. Otherwise credit <= 0.
- Channels are fully independent; all CH_NUM channels may pop in the same cycle, concurrently with one write.
- Same-cycle write and pop of the same slot cannot both succeed: the slot is valid, so the write is blocked. Write ready rises the cycle after the pop.
- Write to a non-head slot while the head is empty: stored; rvalid stays 0 until the head slot fills.
- rvalid/rdata held stable while rready is low (AXI-style, no retraction).
- rob_err_o clears only on reset.

Decomposition:
- Shared package bank_pkg: CH_NUM, ROB_DEPTH, ROB_NUM_W, XBAR_DATA_W constants; channel-id typedef.
- One natural sub-module, bank_xbar_rob_ch: one channel's slot array, head pointer and credit flop. Instantiated CH_NUM times.
- Top level does write-port decode, ready/error logic and output concatenation.

Test Plan:
- Ch0 writes rob 0,1,2 in order, rready=1 -> rvalid one cycle after each write, data out in order 0,1,2, three credit pulses on xbar_isu_credit_o[0].
- Ch1 writes rob 2, then 0, then 1 with rready=1 -> no rvalid after rob 2; rob 0 released, then rob 1, then rob 2 on consecutive cycles.
- Ch2 sends 12 in-order responses (rob 0..7, then 0..3) with pops in between -> head wraps 7->0, 12 responses in order, 12 credits, no error.
- Ch0 rob 0 filled, rready[0]=0 for 5 cycles -> rvalid/rdata stable; second write to rob 0 sees ready=0 and sets rob_err_o; after the pop, ready=1 next cycle.
- Write with channel_id=3 -> ready=1, no channel's rvalid changes, rob_err_o=1 and stays set until rst_i.
- Entries pending on all 3 channels, all rready=1 in the same cycle -> three pops, credit=3'b111 next cycle; assert rst_i mid-stream -> all rvalid=0 and credit=0 the following cycle.
